// File: rtl/cpu6_exmem_stage.sv
// cpu6 EX->MEM->WB back end: operand bypass, EX/MEM and MEM/WB registers,
// load-use / memory-wait stall generation and the regfile write port.
module cpu6_exmem_stage #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter bit FWD_EN      = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   validE,
  input  logic [RFIDX_WIDTH-1:0] rs1idxE,
  input  logic [RFIDX_WIDTH-1:0] rs2idxE,
  input  logic [XLEN-1:0]        rs1rfE,
  input  logic [XLEN-1:0]        rs2rfE,
  output logic [XLEN-1:0]        rs1E,
  output logic [XLEN-1:0]        rs2E,
  input  logic [XLEN-1:0]        aluoutE,
  input  logic [XLEN-1:0]        pcplus4E,
  input  logic [RFIDX_WIDTH-1:0] writeregE,
  input  logic                   regwriteE,
  input  logic                   memtoregE,
  input  logic                   memwriteE,
  input  logic                   jumpE,
  input  logic                   flushE,
  output logic                   stallE,
  output logic                   memreqM,
  output logic                   memwriteM,
  output logic [XLEN-1:0]        dataaddrM,
  output logic [XLEN-1:0]        writedataM,
  input  logic [XLEN-1:0]        readdataM,
  input  logic                   memackM,
  output logic                   regwriteW,
  output logic [RFIDX_WIDTH-1:0] writeregW,
  output logic [XLEN-1:0]        rdW
);

  // A producing stage matches a source only if it will really write a
  // non-zero register; x0 is never forwarded or stalled on.
  function automatic logic src_match(input logic                   vld,
                                     input logic                   rw,
                                     input logic [RFIDX_WIDTH-1:0] dst,
                                     input logic [RFIDX_WIDTH-1:0] idx);
    return vld & rw & (dst != '0) & (dst == idx);
  endfunction

  // M stage state
  logic                   validM_q,    validM_d;
  logic                   regwriteM_q, regwriteM_d;
  logic                   memtoregM_q, memtoregM_d;
  logic                   memwriteM_q, memwriteM_d;
  logic                   jumpM_q,     jumpM_d;
  logic [XLEN-1:0]        aluoutM_q,   aluoutM_d;
  logic [XLEN-1:0]        wdataM_q,    wdataM_d;
  logic [XLEN-1:0]        pcplus4M_q,  pcplus4M_d;
  logic [RFIDX_WIDTH-1:0] writeregM_q, writeregM_d;

  // W stage state
  logic                   regwriteW_q, regwriteW_d;
  logic [RFIDX_WIDTH-1:0] writeregW_q, writeregW_d;
  logic [XLEN-1:0]        rdW_q,       rdW_d;

  logic            doneM, holdM;
  logic            haz1, haz2;
  logic            m1, m2, w1, w2;
  logic [XLEN-1:0] mvalM;

  assign memreqM    = validM_q & (memtoregM_q | memwriteM_q);
  assign memwriteM  = memreqM & memwriteM_q;
  assign dataaddrM  = aluoutM_q;
  assign writedataM = wdataM_q;
  assign doneM      = validM_q & (~memreqM | memackM);
  assign holdM      = validM_q & ~doneM;

  assign mvalM = jumpM_q ? pcplus4M_q : aluoutM_q;
  assign m1    = src_match(validM_q, regwriteM_q, writeregM_q, rs1idxE);
  assign m2    = src_match(validM_q, regwriteM_q, writeregM_q, rs2idxE);
  assign w1    = src_match(regwriteW_q, 1'b1, writeregW_q, rs1idxE);
  assign w2    = src_match(regwriteW_q, 1'b1, writeregW_q, rs2idxE);

  // Operand resolution: M has priority over W; a load still in M cannot be
  // bypassed and raises a hazard. Without bypass any pending write stalls.
  always_comb begin
    rs1E = rs1rfE;
    rs2E = rs2rfE;
    haz1 = 1'b0;
    haz2 = 1'b0;
    if (FWD_EN) begin
      if (m1) begin
        if (memtoregM_q) haz1 = 1'b1;
        else             rs1E = mvalM;
      end else if (w1) begin
        rs1E = rdW_q;
      end
      if (m2) begin
        if (memtoregM_q) haz2 = 1'b1;
        else             rs2E = mvalM;
      end else if (w2) begin
        rs2E = rdW_q;
      end
    end else begin
      haz1 = m1 | w1;
      haz2 = m2 | w2;
    end
  end

  // A flushed EX instruction never stalls; it simply becomes a bubble.
  assign stallE = validE & ~flushE & (haz1 | haz2 | holdM);

  // M next state: hold while memory is busy, else capture EX or bubble.
  always_comb begin
    validM_d    = validM_q;
    regwriteM_d = regwriteM_q;
    memtoregM_d = memtoregM_q;
    memwriteM_d = memwriteM_q;
    jumpM_d     = jumpM_q;
    aluoutM_d   = aluoutM_q;
    wdataM_d    = wdataM_q;
    pcplus4M_d  = pcplus4M_q;
    writeregM_d = writeregM_q;
    if (!holdM) begin
      if (validE && !flushE && !stallE) begin
        validM_d    = 1'b1;
        regwriteM_d = regwriteE;
        memtoregM_d = memtoregE;
        memwriteM_d = memwriteE;
        jumpM_d     = jumpE;
        aluoutM_d   = aluoutE;
        wdataM_d    = rs2E;
        pcplus4M_d  = pcplus4E;
        writeregM_d = writeregE;
      end else begin
        validM_d = 1'b0;
      end
    end
  end

  // W next state: write-back lasts exactly the cycle after M completes.
  always_comb begin
    regwriteW_d = doneM & regwriteM_q;
    writeregW_d = writeregW_q;
    rdW_d       = rdW_q;
    if (doneM) begin
      writeregW_d = writeregM_q;
      rdW_d       = jumpM_q ? pcplus4M_q : (memtoregM_q ? readdataM : aluoutM_q);
    end
  end

  // Pipeline registers; reset abandons any pending access.
  always_ff @(posedge clk) begin
    if (reset) begin
      validM_q    <= 1'b0;
      regwriteM_q <= 1'b0;
      memtoregM_q <= 1'b0;
      memwriteM_q <= 1'b0;
      jumpM_q     <= 1'b0;
      aluoutM_q   <= '0;
      wdataM_q    <= '0;
      pcplus4M_q  <= '0;
      writeregM_q <= '0;
      regwriteW_q <= 1'b0;
      writeregW_q <= '0;
      rdW_q       <= '0;
    end else begin
      validM_q    <= validM_d;
      regwriteM_q <= regwriteM_d;
      memtoregM_q <= memtoregM_d;
      memwriteM_q <= memwriteM_d;
      jumpM_q     <= jumpM_d;
      aluoutM_q   <= aluoutM_d;
      wdataM_q    <= wdataM_d;
      pcplus4M_q  <= pcplus4M_d;
      writeregM_q <= writeregM_d;
      regwriteW_q <= regwriteW_d;
      writeregW_q <= writeregW_d;
      rdW_q       <= rdW_d;
    end
  end

  assign regwriteW = regwriteW_q;
  assign writeregW = writeregW_q;
  assign rdW       = rdW_q;

endmodule

// File: tb/tb_cpu6_exmem_stage.sv
// Directed bench for cpu6_exmem_stage: a per-cycle vector table for the
// bypass / load-use / link / flush path, plus hand-written sequences for
// memory wait, reset mid-request and the no-bypass configuration.
module tb_cpu6_exmem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        validE, flushE;
  logic [4:0]  rs1idxE, rs2idxE, writeregE;
  logic [31:0] rs1rfE, rs2rfE, aluoutE, pcplus4E, readdataM;
  logic        regwriteE, memtoregE, memwriteE, jumpE, memackM;

  logic [31:0] rs1E, rs2E, dataaddrM, writedataM, rdW;
  logic        stallE, memreqM, memwriteM, regwriteW;
  logic [4:0]  writeregW;

  logic [31:0] rs1E_0, rs2E_0, dataaddrM_0, writedataM_0, rdW_0;
  logic        stallE_0, memreqM_0, memwriteM_0, regwriteW_0;
  logic [4:0]  writeregW_0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cpu6_exmem_stage #(.XLEN(32), .RFIDX_WIDTH(5), .FWD_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .validE(validE),
    .rs1idxE(rs1idxE), .rs2idxE(rs2idxE), .rs1rfE(rs1rfE), .rs2rfE(rs2rfE),
    .rs1E(rs1E), .rs2E(rs2E), .aluoutE(aluoutE), .pcplus4E(pcplus4E),
    .writeregE(writeregE), .regwriteE(regwriteE), .memtoregE(memtoregE),
    .memwriteE(memwriteE), .jumpE(jumpE), .flushE(flushE), .stallE(stallE),
    .memreqM(memreqM), .memwriteM(memwriteM), .dataaddrM(dataaddrM),
    .writedataM(writedataM), .readdataM(readdataM), .memackM(memackM),
    .regwriteW(regwriteW), .writeregW(writeregW), .rdW(rdW));

  cpu6_exmem_stage #(.XLEN(32), .RFIDX_WIDTH(5), .FWD_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .validE(validE),
    .rs1idxE(rs1idxE), .rs2idxE(rs2idxE), .rs1rfE(rs1rfE), .rs2rfE(rs2rfE),
    .rs1E(rs1E_0), .rs2E(rs2E_0), .aluoutE(aluoutE), .pcplus4E(pcplus4E),
    .writeregE(writeregE), .regwriteE(regwriteE), .memtoregE(memtoregE),
    .memwriteE(memwriteE), .jumpE(jumpE), .flushE(flushE), .stallE(stallE_0),
    .memreqM(memreqM_0), .memwriteM(memwriteM_0), .dataaddrM(dataaddrM_0),
    .writedataM(writedataM_0), .readdataM(readdataM), .memackM(memackM),
    .regwriteW(regwriteW_0), .writeregW(writeregW_0), .rdW(rdW_0));

  typedef struct {
    logic        vE;
    logic        fl;
    logic [4:0]  r1;
    logic [31:0] rf1;
    logic [4:0]  r2;
    logic [31:0] rf2;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [4:0]  wr;
    logic        rw;
    logic        m2r;
    logic        mw;
    logic        jp;
    logic        ack;
    logic [31:0] rd;
    logic [2:0]  mask;   // bit0 operands, bit1 stall/req/regwriteW, bit2 W data
    logic [31:0] e_rs1;
    logic [31:0] e_rs2;
    logic        e_st;
    logic        e_rq;
    logic        e_rwW;
    logic [4:0]  e_wrW;
    logic [31:0] e_rdW;
  } vec_t;

  vec_t tbl [0:12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    validE = 0; flushE = 0; rs1idxE = 0; rs2idxE = 0; rs1rfE = 0; rs2rfE = 0;
    aluoutE = 0; pcplus4E = 0; writeregE = 0; regwriteE = 0; memtoregE = 0;
    memwriteE = 0; jumpE = 0; memackM = 0; readdataM = 0;
  endtask

  task automatic apply(input vec_t v);
    validE = v.vE; flushE = v.fl; rs1idxE = v.r1; rs1rfE = v.rf1;
    rs2idxE = v.r2; rs2rfE = v.rf2; aluoutE = v.alu; pcplus4E = v.pc4;
    writeregE = v.wr; regwriteE = v.rw; memtoregE = v.m2r; memwriteE = v.mw;
    jumpE = v.jp; memackM = v.ack; readdataM = v.rd;
  endtask

  task automatic reset_all();
    @(negedge clk);
    set_idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    //             vE fl r1  rf1           r2  rf2    alu           pc4           wr  rw  m2r mw  jp  ack rd              mask e_rs1         e_rs2         st  rq  rwW wrW e_rdW
    tbl[0]  = '{1'b0,1'b0,5'd3,32'h11,     5'd0,32'h0, 32'h0,       32'h0,       5'd0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        3'd3,32'h11,       32'h0,       1'b0,1'b0,1'b0,5'd0,32'h0};
    tbl[1]  = '{1'b1,1'b0,5'd0,32'h0,      5'd0,32'h0, 32'h5,       32'h0,       5'd1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        3'd3,32'h0,        32'h0,       1'b0,1'b0,1'b0,5'd0,32'h0};
    tbl[2]  = '{1'b1,1'b0,5'd1,32'hAA,     5'd0,32'h0, 32'h9,       32'h0,       5'd3,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        3'd3,32'h5,        32'h0,       1'b0,1'b0,1'b0,5'd0,32'h0};
    tbl[3]  = '{1'b1,1'b0,5'd1,32'hAA,     5'd3,32'hBB,32'h0,       32'h0,       5'd0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        3'd7,32'h5,        32'h9,       1'b0,1'b0,1'b1,5'd1,32'h5};
    tbl[4]  = '{1'b1,1'b0,5'd0,32'h0,      5'd0,32'h0, 32'h100,     32'h0,       5'd2,1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,        3'd7,32'h0,        32'h0,       1'b0,1'b0,1'b1,5'd3,32'h9};
    tbl[5]  = '{1'b1,1'b0,5'd0,32'h0,      5'd2,32'h55,32'h20,      32'h0,       5'd4,1'b1,1'b0,1'b0,1'b0,1'b1,32'hDEADBEEF, 3'd2,32'h0,        32'h0,       1'b1,1'b1,1'b0,5'd0,32'h0};
    tbl[6]  = '{1'b1,1'b0,5'd0,32'h0,      5'd2,32'h55,32'h20,      32'h0,       5'd4,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        3'd7,32'h0,        32'hDEADBEEF,1'b0,1'b0,1'b1,5'd2,32'hDEADBEEF};
    tbl[7]  = '{1'b1,1'b0,5'd0,32'h0,      5'd0,32'h0, 32'h999,     32'h104,     5'd5,1'b1,1'b0,1'b0,1'b1,1'b0,32'h0,        3'd3,32'h0,        32'h0,       1'b0,1'b0,1'b0,5'd0,32'h0};
    tbl[8]  = '{1'b1,1'b0,5'd5,32'h0,      5'd0,32'h0, 32'h7,       32'h0,       5'd0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        3'd7,32'h104,      32'h0,       1'b0,1'b0,1'b1,5'd4,32'h20};
    tbl[9]  = '{1'b1,1'b0,5'd0,32'h0,      5'd5,32'h0, 32'h0,       32'h0,       5'd0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        3'd7,32'h0,        32'h104,     1'b0,1'b0,1'b1,5'd5,32'h104};
    tbl[10] = '{1'b1,1'b0,5'd0,32'h0,      5'd0,32'h0, 32'h200,     32'h0,       5'd6,1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,        3'd7,32'h0,        32'h0,       1'b0,1'b0,1'b1,5'd0,32'h7};
    tbl[11] = '{1'b1,1'b1,5'd6,32'h0,      5'd0,32'h0, 32'h0,       32'h0,       5'd7,1'b1,1'b0,1'b0,1'b0,1'b1,32'h12345678, 3'd2,32'h0,        32'h0,       1'b0,1'b1,1'b0,5'd0,32'h0};
    tbl[12] = '{1'b0,1'b0,5'd0,32'h0,      5'd0,32'h0, 32'h0,       32'h0,       5'd0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        3'd7,32'h0,        32'h0,       1'b0,1'b0,1'b1,5'd6,32'h12345678};

    set_idle();
    reset_all();

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      if (tbl[i].mask[0]) begin
        chk($sformatf("v%0d rs1E", i), rs1E, tbl[i].e_rs1);
        chk($sformatf("v%0d rs2E", i), rs2E, tbl[i].e_rs2);
      end
      if (tbl[i].mask[1]) begin
        chk($sformatf("v%0d stallE", i), {31'd0, stallE}, {31'd0, tbl[i].e_st});
        chk($sformatf("v%0d memreqM", i), {31'd0, memreqM}, {31'd0, tbl[i].e_rq});
        chk($sformatf("v%0d regwriteW", i), {31'd0, regwriteW}, {31'd0, tbl[i].e_rwW});
      end
      if (tbl[i].mask[2]) begin
        chk($sformatf("v%0d writeregW", i), {27'd0, writeregW}, {27'd0, tbl[i].e_wrW});
        chk($sformatf("v%0d rdW", i), rdW, tbl[i].e_rdW);
      end
    end

    // Store with three wait cycles: request stays stable, EX stalls.
    reset_all();
    @(negedge clk);
    set_idle();
    validE = 1; rs2idxE = 5'd9; rs2rfE = 32'hCAFE0001; aluoutE = 32'h300; memwriteE = 1;
    #1 chk("sw rs2E", rs2E, 32'hCAFE0001);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_idle();
      validE = 1; aluoutE = 32'h42; writeregE = 5'd8; regwriteE = 1;
      memackM = (i == 3);
      #1;
      chk($sformatf("wait%0d memreqM", i), {31'd0, memreqM}, 32'd1);
      chk($sformatf("wait%0d memwriteM", i), {31'd0, memwriteM}, 32'd1);
      chk($sformatf("wait%0d dataaddrM", i), dataaddrM, 32'h300);
      chk($sformatf("wait%0d writedataM", i), writedataM, 32'hCAFE0001);
      chk($sformatf("wait%0d stallE", i), {31'd0, stallE}, (i == 3) ? 32'd0 : 32'd1);
      chk($sformatf("wait%0d regwriteW", i), {31'd0, regwriteW}, 32'd0);
    end
    @(negedge clk);
    set_idle();
    #1;
    chk("post-ack memreqM", {31'd0, memreqM}, 32'd0);
    chk("post-ack memwriteM", {31'd0, memwriteM}, 32'd0);
    chk("post-ack regwriteW", {31'd0, regwriteW}, 32'd0);
    @(negedge clk);
    #1;
    chk("after-sw regwriteW", {31'd0, regwriteW}, 32'd1);
    chk("after-sw writeregW", {27'd0, writeregW}, 32'd8);
    chk("after-sw rdW", rdW, 32'h42);

    // Reset while a load waits for its ack.
    reset_all();
    @(negedge clk);
    set_idle();
    validE = 1; aluoutE = 32'h400; writeregE = 5'd9; regwriteE = 1; memtoregE = 1;
    @(negedge clk);
    set_idle();
    #1 chk("rst pre memreqM", {31'd0, memreqM}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    memackM = 1; readdataM = 32'h77;
    #1;
    chk("rst memreqM", {31'd0, memreqM}, 32'd0);
    chk("rst regwriteW", {31'd0, regwriteW}, 32'd0);
    @(negedge clk);
    set_idle();
    #1 chk("rst no W write", {31'd0, regwriteW}, 32'd0);

    // No-bypass configuration: dependent waits until the producer leaves W.
    reset_all();
    #1;
    chk("nofwd reset regwriteW", {31'd0, regwriteW_0}, 32'd0);
    chk("nofwd reset memreqM", {31'd0, memreqM_0}, 32'd0);
    @(negedge clk);
    set_idle();
    validE = 1; aluoutE = 32'h5; writeregE = 5'd1; regwriteE = 1;
    #1 chk("nofwd producer stallE", {31'd0, stallE_0}, 32'd0);
    @(negedge clk);
    set_idle();
    validE = 1; rs1idxE = 5'd1; rs1rfE = 32'h0;
    #1;
    chk("nofwd M stallE", {31'd0, stallE_0}, 32'd1);
    chk("nofwd M rs1E", rs1E_0, 32'h0);
    @(negedge clk);
    #1;
    chk("nofwd W stallE", {31'd0, stallE_0}, 32'd1);
    chk("nofwd W regwriteW", {31'd0, regwriteW_0}, 32'd1);
    @(negedge clk);
    rs1rfE = 32'h5;
    #1;
    chk("nofwd rf stallE", {31'd0, stallE_0}, 32'd0);
    chk("nofwd rf rs1E", rs1E_0, 32'h5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
